alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i  input  1  synchronous, active-low reset, sampled on clk_i rising edge.
REQ-003 SHALL have ports req0_valid_i / req1_valid_i  input  1  requester n has an operation pending.
REQ-004 SHALL have ports req0_ready_o / req1_ready_o  output  1  request accepted this cycle when valid & ready.
REQ-005 SHALL have ports req0_ctrl_i / req1_ctrl_i  input  4  ALU control code: 0010 add, 0110 sub, 0000 and, 0001 or, 1111 mul.
REQ-006 SHALL have ports req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i  input  32  operands.
REQ-007 SHALL have ports alu_ctrl_o  output  4, and alu_data1_o, alu_data2_o  output  32; these drive the shared ALU.
REQ-008 SHALL have port alu_data_i  input  32  shared ALU result, treated as combinational from alu_* outputs.
REQ-009 SHALL have ports resp_valid_o  output  1, resp_ready_i  input  1, resp_id_o  output  1 (requester index), resp_data_o  output  32, resp_err_o  output  1 (unsupported code).
REQ-010 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, MUL2, RESP.
REQ-012 SHALL assert at most one reqN_ready_o per cycle, and only in IDLE.
REQ-013 Arbitration SHALL be round-robin: if both valid, grant the requester not granted last; if only one valid, grant it; last-grant pointer updates only on accepted handshake.
REQ-014 reqN_ready_o SHALL be combinational from the valids and the pointer in IDLE (no cycle of delay).
REQ-015 On accept, SHALL latch ctrl, data1, data2 and requester id into internal registers; requester payload is don't-care afterward.
REQ-016 Accept with supported code SHALL go IDLE->EXEC; with code 1111 EXEC->MUL2->RESP; other supported codes EXEC->RESP.
REQ-017 Accept with unsupported code SHALL go IDLE->RESP directly with resp_err_o=1, resp_data_o=0, and no ALU sequencing.
REQ-018 alu_ctrl_o/alu_data1_o/alu_data2_o SHALL be driven from latched registers and remain stable through EXEC and MUL2; they hold their last values in IDLE and RESP.
REQ-019 SHALL capture alu_data_i into the result register on the last execute cycle: EXEC for non-mul, MUL2 for mul.
REQ-020 Latency, accept edge = cycle N: resp_valid_o high from N+2 (add/sub/and/or), N+3 (mul), N+1 (unsupported).
REQ-021 In RESP, resp_valid_o, resp_id_o, resp_data_o and resp_err_o SHALL hold stable until resp_ready_i=1; the handshake cycle returns to IDLE.
REQ-022 A new request SHALL NOT be accepted in the RESP handshake cycle; earliest next accept is the following cycle in IDLE (one op in flight, no overlap).
REQ-023 Results SHALL be the low 32 bits (wrap-around) for add, sub and mul; no overflow indication.
REQ-024 Changes on the req inputs while not IDLE SHALL have no effect on the in-flight operation.
REQ-025 resp_err_o SHALL be 0 for all supported codes.

Reset
REQ-026 When rst_i=0 at a clock edge, SHALL enter IDLE and set: pointer = requester 1 (requester 0 wins first contention), resp_valid_o=0, resp_err_o=0, resp_id_o=0, resp_data_o=0, alu_ctrl_o=0, alu_data1_o=0, alu_data2_o=0, busy_o=0, and all ready outputs 0 during reset.
REQ-027 Reset asserted mid-operation (EXEC, MUL2 or RESP) SHALL abort the operation, with no response emitted after reset release.

Verification
REQ-028 Single request: req0 add, 5 and 7, resp_ready_i=1 -> ready0 at N; resp_valid_o at N+2 with data 12, id 0, err 0; busy_o low at N+3.
REQ-029 Contention: both valid from reset; req0 sub 10-3, req1 or 0xF0|0x0F -> req0 served first (7), then req1 (0xFF, id 1); with both still valid, next grant goes to req0.
REQ-030 Multiply wrap: req1 mul 0x10000 * 0x10000 -> resp_valid_o at N+3, data 0x00000000; alu_ctrl_o=1111 held during EXEC and MUL2.
REQ-031 Unsupported code 0101 -> resp_valid_o at N+1, err 1, data 0; alu_ctrl_o unchanged.
REQ-032 Backpressure: resp_ready_i=0 for 4 cycles in RESP, with req1_valid_i high -> response fields stable, req1_ready_o stays 0; req1 accepted only after the handshake cycle plus one.
REQ-033 Reset in MUL2: rst_i=0 for one cycle -> next cycle IDLE, all outputs at reset values, no response emitted.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// One operation is in flight at a time; multiply takes an extra execute cycle.
module alu_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    input  logic        req1_valid_i,
    output logic        req0_ready_o,
    output logic        req1_ready_o,
    input  logic [3:0]  req0_ctrl_i,
    input  logic [3:0]  req1_ctrl_i,
    input  logic [31:0] req0_data1_i,
    input  logic [31:0] req0_data2_i,
    input  logic [31:0] req1_data1_i,
    input  logic [31:0] req1_data2_i,
    output logic [3:0]  alu_ctrl_o,
    output logic [31:0] alu_data1_o,
    output logic [31:0] alu_data2_o,
    input  logic [31:0] alu_data_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic        resp_id_o,
    output logic [31:0] resp_data_o,
    output logic        resp_err_o,
    output logic        busy_o
);

    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_MUL = 4'b1111;

    typedef enum logic [1:0] {IDLE, EXEC, MUL2, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic [3:0]  sel_ctrl;
    logic        sel_supported;
    logic [3:0]  alu_ctrl_q;
    logic [31:0] alu_data1_q;
    logic [31:0] alu_data2_q;
    logic        id_q;
    logic [31:0] result_q;
    logic        err_q;

    function automatic logic is_supported(input logic [3:0] ctrl);
        case (ctrl)
            CTRL_ADD, CTRL_SUB, CTRL_AND, CTRL_OR, CTRL_MUL: is_supported = 1'b1;
            default:                                         is_supported = 1'b0;
        endcase
    endfunction

    // Round-robin grant: on contention the requester not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_i && state == IDLE) begin
            grant0 = req0_valid_i && (!req1_valid_i || last_grant);
            grant1 = req1_valid_i && (!req0_valid_i || !last_grant);
        end
        accept        = grant0 | grant1;
        sel_ctrl      = grant1 ? req1_ctrl_i : req0_ctrl_i;
        sel_supported = is_supported(sel_ctrl);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = sel_supported ? EXEC : RESP;
                end
            end
            EXEC:    state_next = (alu_ctrl_q == CTRL_MUL) ? MUL2 : RESP;
            MUL2:    state_next = RESP;
            RESP: begin
                if (resp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready_o = grant0;
        req1_ready_o = grant1;
        busy_o       = (state != IDLE);
        resp_valid_o = (state == RESP);
    end

    // Unsupported codes never reach the ALU, so its operand registers keep their old values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_grant  <= 1'b1;
            alu_ctrl_q  <= 4'b0000;
            alu_data1_q <= 32'd0;
            alu_data2_q <= 32'd0;
            id_q        <= 1'b0;
            result_q    <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                last_grant <= grant1;
                id_q       <= grant1;
                if (sel_supported) begin
                    alu_ctrl_q  <= sel_ctrl;
                    alu_data1_q <= grant1 ? req1_data1_i : req0_data1_i;
                    alu_data2_q <= grant1 ? req1_data2_i : req0_data2_i;
                    err_q       <= 1'b0;
                end else begin
                    result_q <= 32'd0;
                    err_q    <= 1'b1;
                end
            end
            if ((state == EXEC && alu_ctrl_q != CTRL_MUL) || state == MUL2) begin
                result_q <= alu_data_i;
            end
        end
    end

    assign alu_ctrl_o  = alu_ctrl_q;
    assign alu_data1_o = alu_data1_q;
    assign alu_data2_o = alu_data2_q;
    assign resp_id_o   = id_q;
    assign resp_data_o = result_q;
    assign resp_err_o  = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
// Covers reset, contention, a vector table of single ops, backpressure and reset mid-multiply.
module tb_alu_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [3:0]  req0_ctrl_i, req1_ctrl_i;
    logic [31:0] req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_data1_o, alu_data2_o, alu_data_i;
    logic        resp_valid_o, resp_ready_i, resp_id_o, resp_err_o, busy_o;
    logic [31:0] resp_data_o;

    int          checks = 0;
    int          failures = 0;
    logic [3:0]  last_alu_ctrl;

    typedef struct {
        logic        id;
        logic [3:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    alu_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req1_valid_i(req1_valid_i),
        .req0_ready_o(req0_ready_o), .req1_ready_o(req1_ready_o),
        .req0_ctrl_i(req0_ctrl_i), .req1_ctrl_i(req1_ctrl_i),
        .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i),
        .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i),
        .alu_ctrl_o(alu_ctrl_o), .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o),
        .alu_data_i(alu_data_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
        .resp_data_o(resp_data_o), .resp_err_o(resp_err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Shared ALU stand-in, purely combinational from the arbiter's alu_* outputs.
    always_comb begin
        alu_data_i = 32'hDEADBEEF;
        case (alu_ctrl_o)
            4'b0010: alu_data_i = alu_data1_o + alu_data2_o;
            4'b0110: alu_data_i = alu_data1_o - alu_data2_o;
            4'b0000: alu_data_i = alu_data1_o & alu_data2_o;
            4'b0001: alu_data_i = alu_data1_o | alu_data2_o;
            4'b1111: alu_data_i = alu_data1_o * alu_data2_o;
            default: alu_data_i = 32'hDEADBEEF;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic id, input logic [3:0] ctrl, input logic [31:0] d1, input logic [31:0] d2);
        if (id) begin
            req1_valid_i = 1'b1; req1_ctrl_i = ctrl; req1_data1_i = d1; req1_data2_i = d2;
        end else begin
            req0_valid_i = 1'b1; req0_ctrl_i = ctrl; req0_data1_i = d1; req0_data2_i = d2;
        end
    endtask

    task automatic runOp(input vec_t v);
        int lat;
        @(negedge clk_i);
        resp_ready_i = 1'b1;
        applyStimulus(v.id, v.ctrl, v.d1, v.d2);
        #1;
        checkOutput("ready_at_accept", 32'(v.id ? req1_ready_o : req0_ready_o), 32'd1);
        @(negedge clk_i);
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        lat = 1;
        while (!resp_valid_o && lat < 8) begin
            checkOutput("alu_ctrl_exec", 32'(alu_ctrl_o), 32'(v.ctrl));
            checkOutput("alu_data1_exec", alu_data1_o, v.d1);
            @(negedge clk_i);
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(v.exp_lat));
        checkOutput("alu_ctrl_resp", 32'(alu_ctrl_o), 32'(v.exp_err ? last_alu_ctrl : v.ctrl));
        checkOutput("resp_data", resp_data_o, v.exp_data);
        checkOutput("resp_id", 32'(resp_id_o), 32'(v.id));
        checkOutput("resp_err", 32'(resp_err_o), 32'(v.exp_err));
        @(negedge clk_i);
        checkOutput("busy_after_handshake", 32'(busy_o), 32'd0);
        checkOutput("valid_after_handshake", 32'(resp_valid_o), 32'd0);
        if (!v.exp_err) last_alu_ctrl = v.ctrl;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 4'b0010, 32'd5,          32'd7,          32'd12,         1'b0, 2};
        vecs[1] = '{1'b1, 4'b1111, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000,  1'b0, 3};
        vecs[2] = '{1'b0, 4'b0101, 32'd9,          32'd9,          32'h0000_0000,  1'b1, 1};
        vecs[3] = '{1'b1, 4'b0110, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 2};
        vecs[4] = '{1'b0, 4'b0000, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 2};
        vecs[5] = '{1'b1, 4'b0001, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678,  1'b0, 2};
        vecs[6] = '{1'b0, 4'b1111, 32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD,  1'b0, 3};
        vecs[7] = '{1'b1, 4'b0010, 32'hFFFF_FFFF,  32'd2,          32'd1,          1'b0, 2};
        vecs[8] = '{1'b0, 4'b1010, 32'd1,          32'd1,          32'h0000_0000,  1'b1, 1};

        // Reset with both requesters already pending.
        rst_i = 1'b0;
        resp_ready_i = 1'b1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        applyStimulus(1'b0, 4'b0110, 32'd10, 32'd3);
        applyStimulus(1'b1, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
        repeat (3) @(negedge clk_i);
        checkOutput("rst_ready0", 32'(req0_ready_o), 32'd0);
        checkOutput("rst_ready1", 32'(req1_ready_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        checkOutput("rst_alu_ctrl", 32'(alu_ctrl_o), 32'd0);
        checkOutput("rst_alu_data1", alu_data1_o, 32'd0);
        checkOutput("rst_alu_data2", alu_data2_o, 32'd0);
        checkOutput("rst_resp_data", resp_data_o, 32'd0);
        checkOutput("rst_resp_id", 32'(resp_id_o), 32'd0);
        checkOutput("rst_resp_err", 32'(resp_err_o), 32'd0);

        // Contention: req0 first, then req1, then back to req0.
        rst_i = 1'b1;
        #1;
        checkOutput("cont_ready0_first", 32'(req0_ready_o), 32'd1);
        checkOutput("cont_ready1_first", 32'(req1_ready_o), 32'd0);
        @(negedge clk_i);
        checkOutput("cont_busy_exec", 32'(busy_o), 32'd1);
        checkOutput("cont_no_ready_exec", 32'({req0_ready_o, req1_ready_o}), 32'd0);
        @(negedge clk_i);
        checkOutput("cont_valid0", 32'(resp_valid_o), 32'd1);
        checkOutput("cont_data0", resp_data_o, 32'd7);
        checkOutput("cont_id0", 32'(resp_id_o), 32'd0);
        @(negedge clk_i);
        checkOutput("cont_ready1_second", 32'(req1_ready_o), 32'd1);
        checkOutput("cont_ready0_second", 32'(req0_ready_o), 32'd0);
        repeat (2) @(negedge clk_i);
        checkOutput("cont_valid1", 32'(resp_valid_o), 32'd1);
        checkOutput("cont_data1", resp_data_o, 32'h0000_00FF);
        checkOutput("cont_id1", 32'(resp_id_o), 32'd1);
        @(negedge clk_i);
        checkOutput("cont_ready0_third", 32'(req0_ready_o), 32'd1);
        checkOutput("cont_ready1_third", 32'(req1_ready_o), 32'd0);
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        last_alu_ctrl = 4'b0001;

        for (int i = 0; i < 9; i++) begin
            runOp(vecs[i]);
        end

        // Backpressure: response held four cycles while req1 waits.
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        applyStimulus(1'b0, 4'b0010, 32'd1, 32'd1);
        #1;
        checkOutput("bp_ready0", 32'(req0_ready_o), 32'd1);
        @(negedge clk_i);
        req0_valid_i = 1'b0;
        applyStimulus(1'b1, 4'b0010, 32'd1, 32'd2);
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_valid_hold", 32'(resp_valid_o), 32'd1);
            checkOutput("bp_data_hold", resp_data_o, 32'd2);
            checkOutput("bp_id_hold", 32'(resp_id_o), 32'd0);
            checkOutput("bp_err_hold", 32'(resp_err_o), 32'd0);
            checkOutput("bp_ready1_blocked", 32'(req1_ready_o), 32'd0);
            @(negedge clk_i);
        end
        resp_ready_i = 1'b1;
        #1;
        checkOutput("bp_handshake_valid", 32'(resp_valid_o), 32'd1);
        checkOutput("bp_handshake_no_accept", 32'(req1_ready_o), 32'd0);
        @(negedge clk_i);
        checkOutput("bp_idle_busy", 32'(busy_o), 32'd0);
        checkOutput("bp_ready1_after", 32'(req1_ready_o), 32'd1);
        @(negedge clk_i);
        req1_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("bp_req1_valid", 32'(resp_valid_o), 32'd1);
        checkOutput("bp_req1_data", resp_data_o, 32'd3);
        checkOutput("bp_req1_id", 32'(resp_id_o), 32'd1);
        @(negedge clk_i);

        // Reset asserted during the second multiply cycle.
        applyStimulus(1'b1, 4'b1111, 32'd6, 32'd7);
        #1;
        checkOutput("mrst_ready1", 32'(req1_ready_o), 32'd1);
        @(negedge clk_i);
        req1_valid_i = 1'b0;
        checkOutput("mrst_alu_ctrl_exec", 32'(alu_ctrl_o), 32'hF);
        @(negedge clk_i);
        checkOutput("mrst_alu_ctrl_mul2", 32'(alu_ctrl_o), 32'hF);
        checkOutput("mrst_busy_mul2", 32'(busy_o), 32'd1);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        checkOutput("mrst_busy", 32'(busy_o), 32'd0);
        checkOutput("mrst_resp_valid", 32'(resp_valid_o), 32'd0);
        checkOutput("mrst_alu_ctrl", 32'(alu_ctrl_o), 32'd0);
        checkOutput("mrst_alu_data1", alu_data1_o, 32'd0);
        checkOutput("mrst_resp_data", resp_data_o, 32'd0);
        checkOutput("mrst_resp_id", 32'(resp_id_o), 32'd0);
        checkOutput("mrst_resp_err", 32'(resp_err_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checkOutput("mrst_no_response", 32'(resp_valid_o), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
